// File: rtl/avalon_burst_master.sv
// avalon_burst_master
//   Avalon-MM master engine for the Sobel datapath. A command streams a block
//   of words from memory into a small prefetch FIFO using pipelined reads
//   (readdatavalid responses). Single-word result writes are interleaved on
//   the same bus, and a pending write takes priority over the next read.
//
// Ports
//   clk, n_rst           clock, synchronous active-low reset
//   cmd_start/addr/count start a read block (ignored while cmd_busy)
//   cmd_busy, cmd_done   block in progress / 1-cycle completion pulse
//   rd_data/valid/ready  FIFO head towards the consumer (pop on valid&ready)
//   wr_req/addr/data     single-word write request, accepted when !wr_busy
//   wr_busy              write buffer occupied
//   avm_*                Avalon-MM master interface
module avalon_burst_master #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              cmd_start,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [CNT_W-1:0]  cmd_count,
  output logic              cmd_busy,
  output logic              cmd_done,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_busy,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_readdatavalid,
  input  logic              avm_waitrequest
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(DATA_W / 8);
  localparam logic [CW:0]       DEPTH_C = (CW+1)'(FIFO_DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]        state;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  issued_q;
  logic [CNT_W-1:0]  popped_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [CW-1:0]     outst_q;
  logic [CW-1:0]     fifo_cnt_q;
  logic [PW-1:0]     wr_ptr_q;
  logic [PW-1:0]     rd_ptr_q;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;

  logic              rd_acc;
  logic              wr_acc;
  logic              bus_free;
  logic              push;
  logic              pop;
  logic              start_go;
  logic              start_rd;
  logic              last_pop;
  logic [CW-1:0]     outst_nxt;
  logic [CW-1:0]     fifo_nxt;
  logic [CW:0]       occ_nxt;
  logic [CNT_W-1:0]  issued_nxt;
  logic [ADDR_W-1:0] rd_addr_nxt;
  logic              rd_more;
  logic              wr_pend;
  logic              next_is_wr;
  logic              next_is_rd;
  logic [ADDR_W-1:0] next_rd_addr;

  assign cmd_busy = (state == READ) || (state == DRAIN);
  assign rd_valid = (fifo_cnt_q != '0);
  assign rd_data  = mem[rd_ptr_q];

  always_comb begin
    rd_acc   = avm_read  & ~avm_waitrequest;
    wr_acc   = avm_write & ~avm_waitrequest;
    // The bus may take a new request when nothing is held or the held one
    // is being accepted this cycle.
    bus_free = ~(avm_read | avm_write) | ~avm_waitrequest;
    // Responses with nothing outstanding are stale (issued before a reset).
    push     = avm_readdatavalid && (outst_q != '0);
    pop      = rd_ready && (fifo_cnt_q != '0);
    start_go = (state == IDLE) && cmd_start;
    start_rd = start_go && (cmd_count != '0);
    last_pop = pop && cmd_busy && ((popped_q + CNT_W'(1)) == count_q);

    outst_nxt   = outst_q + CW'(rd_acc) - CW'(push);
    fifo_nxt    = fifo_cnt_q + CW'(push) - CW'(pop);
    occ_nxt     = {1'b0, outst_nxt} + {1'b0, fifo_nxt};
    issued_nxt  = issued_q + CNT_W'(rd_acc);
    rd_addr_nxt = rd_acc ? rd_addr_q + STEP : rd_addr_q;

    // Next-cycle occupancy (outstanding + stored) reserves a FIFO slot for
    // every read before it is issued, so the FIFO can never overflow.
    rd_more = (state == READ) && (issued_nxt < count_q) && (occ_nxt < DEPTH_C);

    wr_pend      = wr_busy && !avm_write;
    next_is_wr   = bus_free && wr_pend;
    next_is_rd   = bus_free && !wr_pend && (rd_more || start_rd);
    next_rd_addr = start_rd ? cmd_addr : rd_addr_nxt;
  end

  // Block sequencing and counters
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state     <= IDLE;
      count_q   <= '0;
      issued_q  <= '0;
      popped_q  <= '0;
      rd_addr_q <= '0;
      cmd_done  <= 1'b0;
    end else begin
      cmd_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_go) begin
            if (cmd_count == '0) begin
              cmd_done <= 1'b1;
            end else begin
              state     <= READ;
              count_q   <= cmd_count;
              rd_addr_q <= cmd_addr;
              issued_q  <= '0;
              popped_q  <= '0;
            end
          end
        end
        READ: begin
          issued_q  <= issued_nxt;
          rd_addr_q <= rd_addr_nxt;
          if (issued_nxt == count_q) state <= DRAIN;
        end
        DRAIN: ;
        default: state <= IDLE;
      endcase

      // Completion is defined by the consumer taking the final word.
      if (last_pop) begin
        state    <= IDLE;
        cmd_done <= 1'b1;
        issued_q <= '0;
        popped_q <= '0;
      end else if (pop && cmd_busy) begin
        popped_q <= popped_q + CNT_W'(1);
      end
    end
  end

  // Prefetch FIFO and outstanding-read tracking
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      outst_q    <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[PW'(i)] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr_q] <= avm_readdata;
        wr_ptr_q      <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      fifo_cnt_q <= fifo_nxt;
      outst_q    <= outst_nxt;
    end
  end

  // Single-entry write buffer
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      wr_busy   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else if (wr_req && !wr_busy) begin
      wr_busy   <= 1'b1;
      wr_addr_q <= wr_addr;
      wr_data_q <= wr_data;
    end else if (wr_acc) begin
      wr_busy <= 1'b0;
    end
  end

  // Bus request registers: only updated when the bus is free, so a stalled
  // request stays stable for the whole waitrequest period.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      avm_read      <= 1'b0;
      avm_write     <= 1'b0;
      avm_address   <= '0;
      avm_writedata <= '0;
    end else if (bus_free) begin
      avm_read  <= next_is_rd;
      avm_write <= next_is_wr;
      if (next_is_wr) begin
        avm_address   <= wr_addr_q;
        avm_writedata <= wr_data_q;
      end else if (next_is_rd) begin
        avm_address <= next_rd_addr;
      end
    end
  end

endmodule

// File: tb/tb_avalon_burst_master.sv
// Bench for avalon_burst_master: a memory slave with programmable stalls and
// held responses, a transaction-level model checked every cycle, and directed
// scenarios with literal expectations.
module tb_avalon_burst_master;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned FIFO_DEPTH = 8;
  localparam int unsigned CNT_W      = 16;
  localparam logic [ADDR_W-1:0] STEP = 4;

  logic              clk = 1'b0;
  logic              n_rst = 1'b0;
  logic              cmd_start = 1'b0;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [CNT_W-1:0]  cmd_count = '0;
  logic              cmd_busy, cmd_done;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_ready = 1'b0;
  logic              wr_req = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              wr_busy;
  logic [ADDR_W-1:0] avm_address;
  logic              avm_read, avm_write;
  logic [DATA_W-1:0] avm_writedata;
  logic [DATA_W-1:0] avm_readdata = '0;
  logic              avm_readdatavalid = 1'b0;
  logic              avm_waitrequest = 1'b0;

  always #5 clk = ~clk;

  avalon_burst_master #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .n_rst(n_rst),
    .cmd_start(cmd_start), .cmd_addr(cmd_addr), .cmd_count(cmd_count),
    .cmd_busy(cmd_busy), .cmd_done(cmd_done),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_busy(wr_busy),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid), .avm_waitrequest(avm_waitrequest)
  );

  int checks = 0;
  int fails  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  // ---------------- memory slave ----------------
  logic [ADDR_W-1:0] rd_log[$];
  logic [ADDR_W-1:0] wr_log_a[$];
  logic [DATA_W-1:0] wr_log_d[$];
  logic [ADDR_W-1:0] resp_q[$];
  logic [ADDR_W-1:0] stall_log[$];
  int stall_idx = -1;
  int stall_len = 0;
  int stall_cnt = 0;
  int reads_before_write = -1;
  bit resp_hold = 1'b0;

  always begin
    @(posedge clk);
    if (n_rst) begin
      if (avm_read && !avm_waitrequest) begin
        rd_log.push_back(avm_address);
        resp_q.push_back(avm_address);
      end
      if (avm_write && !avm_waitrequest) begin
        wr_log_a.push_back(avm_address);
        wr_log_d.push_back(avm_writedata);
        reads_before_write = rd_log.size();
      end
    end
    #1;
    if (!resp_hold && resp_q.size() != 0) begin
      avm_readdatavalid = 1'b1;
      avm_readdata      = mem_word(resp_q.pop_front());
    end else begin
      avm_readdatavalid = 1'b0;
      avm_readdata      = '0;
    end
    if (avm_read && rd_log.size() == stall_idx && stall_cnt < stall_len) begin
      avm_waitrequest = 1'b1;
      stall_cnt++;
      stall_log.push_back(avm_address);
    end else begin
      avm_waitrequest = 1'b0;
    end
  end

  // ---------------- transaction model + per-cycle compare ----------------
  bit                m_busy = 1'b0, m_done_due = 1'b0, m_wr_busy = 1'b0;
  int                m_count = 0, m_issued = 0, m_popped = 0, m_outst = 0;
  logic [ADDR_W-1:0] m_exp_addr = '0, m_wa = '0;
  logic [DATA_W-1:0] m_wd = '0;
  logic [DATA_W-1:0] mq[$];
  bit                prev_stall = 1'b0;
  logic [ADDR_W+DATA_W+1:0] prev_bus = '0;
  int                pops = 0;

  always @(negedge clk) begin
    bit busy_now, wrb_now, done_nxt;
    logic [DATA_W-1:0] tmp;
    check("rd_valid", rd_valid, mq.size() != 0);
    if (mq.size() != 0) check("rd_data", rd_data, mq[0]);
    check("cmd_busy", cmd_busy, m_busy);
    check("cmd_done", cmd_done, m_done_due);
    check("wr_busy", wr_busy, m_wr_busy);
    check("occupancy", (m_outst + mq.size()) <= FIFO_DEPTH, 1);
    if (avm_read) check("read_allowed", m_busy && m_issued < m_count, 1);
    if (avm_read && !avm_waitrequest) check("read_addr", avm_address, m_exp_addr);
    if (avm_write) check("write_allowed", m_wr_busy, 1);
    if (avm_write && !avm_waitrequest) begin
      check("write_addr", avm_address, m_wa);
      check("write_data", avm_writedata, m_wd);
    end
    if (prev_stall)
      check("bus_hold", {avm_read, avm_write, avm_address, avm_writedata}, prev_bus);

    prev_stall = n_rst && (avm_read || avm_write) && avm_waitrequest;
    prev_bus   = {avm_read, avm_write, avm_address, avm_writedata};
    done_nxt   = 1'b0;
    busy_now   = m_busy;
    wrb_now    = m_wr_busy;
    if (!n_rst) begin
      m_busy = 0; m_wr_busy = 0; m_outst = 0; m_issued = 0; m_popped = 0;
      mq.delete();
    end else begin
      if (rd_ready && mq.size() != 0) begin
        tmp = mq.pop_front();
        pops++;
        m_popped++;
        if (m_busy && m_popped == m_count) begin
          done_nxt = 1'b1;
          m_busy   = 1'b0;
        end
      end
      if (avm_readdatavalid && m_outst > 0) begin
        mq.push_back(avm_readdata);
        m_outst--;
      end
      if (avm_read && !avm_waitrequest) begin
        m_outst++;
        m_issued++;
        m_exp_addr = m_exp_addr + STEP;
      end
      if (cmd_start && !busy_now) begin
        if (cmd_count == 0) done_nxt = 1'b1;
        else begin
          m_busy = 1'b1; m_count = cmd_count; m_issued = 0; m_popped = 0;
          m_exp_addr = cmd_addr;
        end
      end
      if (avm_write && !avm_waitrequest) m_wr_busy = 1'b0;
      if (wr_req && !wrb_now) begin
        m_wr_busy = 1'b1; m_wa = wr_addr; m_wd = wr_data;
      end
    end
    m_done_due = done_nxt;
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic clear_logs();
    rd_log.delete(); wr_log_a.delete(); wr_log_d.delete(); stall_log.delete();
    pops = 0; reads_before_write = -1;
  endtask

  task automatic start_cmd(input logic [ADDR_W-1:0] a, input logic [CNT_W-1:0] c);
    cmd_addr = a; cmd_count = c; cmd_start = 1'b1;
    cyc(1);
    cmd_start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int bound);
    bit got = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (cmd_done) begin got = 1'b1; break; end
      cyc(1);
    end
    check(name, got, 1);
    cyc(1);
  endtask

  initial begin
    cyc(3);
    check("reset_outputs", {cmd_busy, cmd_done, rd_valid, wr_busy, avm_read, avm_write,
          rd_data != 0, avm_address != 0, avm_writedata != 0}, 0);
    n_rst = 1'b1;
    cyc(1);

    // Basic 4-word block
    clear_logs(); rd_ready = 1'b1;
    start_cmd(32'h100, 4);
    check("A_first_read", avm_read, 1);
    check("A_first_addr", avm_address, 32'h100);
    wait_done("A_done", 40);
    check("A_reads", rd_log.size(), 4);
    for (int i = 0; i < rd_log.size(); i++) check("A_addr", rd_log[i], 32'h100 + 4 * i);
    check("A_pops", pops, 4);

    // Stall on the second read
    clear_logs(); stall_idx = 1; stall_len = 3; stall_cnt = 0;
    start_cmd(32'h100, 4);
    wait_done("B_done", 40);
    stall_idx = -1;
    check("B_stall_cycles", stall_log.size(), 3);
    for (int i = 0; i < stall_log.size(); i++) check("B_stall_addr", stall_log[i], 32'h104);
    check("B_reads", rd_log.size(), 4);
    if (rd_log.size() == 4) begin
      check("B_addr1", rd_log[1], 32'h104);
      check("B_addr2", rd_log[2], 32'h108);
    end

    // Throttling against FIFO depth
    clear_logs(); rd_ready = 1'b0;
    start_cmd(32'h1000, 20);
    cyc(30);
    check("C_throttle", rd_log.size(), 8);
    check("C_rd_valid", rd_valid, 1);
    rd_ready = 1'b1;
    wait_done("C_done", 120);
    check("C_total", rd_log.size(), 20);
    if (rd_log.size() == 20) check("C_last_addr", rd_log[19], 32'h1000 + 76);
    check("C_pops", pops, 20);

    // Write interleaved with a read block
    clear_logs();
    start_cmd(32'h400, 4);
    wr_addr = 32'h200; wr_data = 32'hDEAD_BEEF; wr_req = 1'b1;
    cyc(1);
    wr_req = 1'b0;
    check("D_wr_busy_set", wr_busy, 1);
    wait_done("D_done", 40);
    check("D_writes", wr_log_a.size(), 1);
    if (wr_log_a.size() == 1) begin
      check("D_wr_addr", wr_log_a[0], 32'h200);
      check("D_wr_data", wr_log_d[0], 32'hDEAD_BEEF);
    end
    check("D_write_slot", reads_before_write, 2);
    check("D_reads", rd_log.size(), 4);
    check("D_wr_busy_clear", wr_busy, 0);

    // Zero-length command
    clear_logs();
    start_cmd(32'h600, 0);
    check("E_done", cmd_done, 1);
    check("E_busy", cmd_busy, 0);
    cyc(3);
    check("E_no_read", rd_log.size(), 0);

    // Address wrap
    clear_logs();
    start_cmd(32'hFFFF_FFFC, 2);
    wait_done("F_done", 40);
    check("F_reads", rd_log.size(), 2);
    if (rd_log.size() == 2) begin
      check("F_addr0", rd_log[0], 32'hFFFF_FFFC);
      check("F_addr1", rd_log[1], 32'h0);
    end

    // Reset mid-block with outstanding reads
    begin
      bit got = 1'b0;
      clear_logs(); resp_hold = 1'b1;
      start_cmd(32'h800, 6);
      for (int i = 0; i < 20; i++) begin
        if (rd_log.size() >= 3) begin got = 1'b1; break; end
        cyc(1);
      end
      check("R_three_out", got, 1);
      n_rst = 1'b0; resp_hold = 1'b0;
      cyc(2);
      check("R_outputs", {cmd_busy, cmd_done, rd_valid, wr_busy, avm_read, avm_write,
            rd_data != 0, avm_address != 0, avm_writedata != 0}, 0);
      n_rst = 1'b1;
      for (int i = 0; i < 5; i++) begin
        cyc(1);
        check("R_late_ignored", rd_valid, 0);
      end
      check("R_busy", cmd_busy, 0);
    end

    cyc(3);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
